// File: rtl/chunked_mem_pkg.sv
// chunked_mem_pkg: state encoding, derived-width helpers and chunk parity for chunked_mem.
package chunked_mem_pkg;
    typedef enum logic [1:0] {CLEAR, IDLE, ARMED} mem_state_e;
    function automatic int calc_nchunk(int word_w, int chunk_w);
        return word_w / chunk_w;
    endfunction
    function automatic int calc_sel_w(int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction
    function automatic int calc_bus_w(int addr_w, int sel_w, int chunk_w);
        return (addr_w > sel_w + chunk_w) ? addr_w : sel_w + chunk_w;
    endfunction
    function automatic logic chunk_parity(logic [63:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/chunked_mem_if.sv
// chunked_mem_if: shared addr/data command bus and result/status signals of chunked_mem.
interface chunked_mem_if #(
    parameter int BUS_W  = 10,
    parameter int WORD_W = 12
);
    logic              read_write;
    logic              write_commit;
    logic [BUS_W-1:0]  addr_data;
    logic [WORD_W-1:0] mem_result;
    logic              mem_valid;
    logic              wr_done;
    logic              busy;
    logic              parity_err;
    modport master(
        output read_write, write_commit, addr_data,
        input  mem_result, mem_valid, wr_done, busy, parity_err
    );
    modport slave(
        input  read_write, write_commit, addr_data,
        output mem_result, mem_valid, wr_done, busy, parity_err
    );
endinterface

// File: rtl/chunk_ram.sv
// chunk_ram: DEPTH x WORD_W store with per-chunk write enables and registered read.
// MEM_PARITY_EN adds one even-parity bit per chunk, checked on read.
module chunk_ram
    import chunked_mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int WORD_W  = 12,
    parameter int CHUNK_W = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WORD_W/CHUNK_W-1:0]   we,
    input  logic [ADDR_W-1:0]           waddr,
    input  logic [WORD_W-1:0]           wdata,
    input  logic                        re,
    input  logic [ADDR_W-1:0]           raddr,
    output logic [WORD_W-1:0]           rdata,
    output logic                        rperr
);
    localparam int NCHUNK = calc_nchunk(WORD_W, CHUNK_W);
    logic [WORD_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk)
        for (int i = 0; i < NCHUNK; i++)
            if (we[i]) mem[waddr][i*CHUNK_W +: CHUNK_W] <= wdata[i*CHUNK_W +: CHUNK_W];
    always_ff @(posedge clk)
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
`ifdef MEM_PARITY_EN
    logic [NCHUNK-1:0] par [2**ADDR_W];
    logic [NCHUNK-1:0] rpar;
    always_ff @(posedge clk)
        for (int i = 0; i < NCHUNK; i++)
            if (we[i]) par[waddr][i] <= chunk_parity(64'(wdata[i*CHUNK_W +: CHUNK_W]));
    always_comb begin
        rpar = '0;
        for (int i = 0; i < NCHUNK; i++)
            rpar[i] = chunk_parity(64'(mem[raddr][i*CHUNK_W +: CHUNK_W])) ^ par[raddr][i];
    end
    always_ff @(posedge clk)
        if (rst) rperr <= 1'b0;
        else if (re) rperr <= |rpar;
`else
    assign rperr = 1'b0;
`endif
endmodule

// File: rtl/chunked_mem.sv
// chunked_mem: word memory written in CHUNK_W pieces over a narrow addr/data bus, cleared after reset.
// Optional MEM_PARITY_EN stores per-chunk parity and reports read mismatches on parity_err.
module chunked_mem
    import chunked_mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int WORD_W  = 12,
    parameter int CHUNK_W = 6
) (
    input logic         clk,
    input logic         rst,
    chunked_mem_if.slave bus
);
    localparam int NCHUNK = calc_nchunk(WORD_W, CHUNK_W);
    localparam int SEL_W  = calc_sel_w(NCHUNK);
    mem_state_e         state, state_n;
    logic [ADDR_W-1:0]  clr_ptr, write_addr;
    logic [NCHUNK-1:0]  mask, mask_n, we;
    logic [SEL_W-1:0]   sel;
    logic [CHUNK_W-1:0] chunk;
    logic               busy, rd, latch, commit, full, wr_done, mem_valid;
    assign busy   = state == CLEAR;
    assign rd     = !busy && bus.read_write;
    assign latch  = !busy && !bus.read_write && !bus.write_commit;
    assign sel    = bus.addr_data[CHUNK_W +: SEL_W];
    assign chunk  = bus.addr_data[CHUNK_W-1:0];
    assign commit = state == ARMED && !bus.read_write && bus.write_commit && 32'(sel) < NCHUNK;
    // The clear sequencer reuses the write port, zeroing every chunk of clr_ptr at once.
    assign we     = busy ? '1 : commit ? NCHUNK'(1) << sel : '0;
    assign mask_n = mask | we;
    assign full   = commit && &mask_n;
    always_comb begin
        state_n = state;
        state_n = (busy && &clr_ptr) ? IDLE : latch ? ARMED : state;
    end
    always_ff @(posedge clk)
        if (rst) state <= CLEAR;
        else state <= state_n;
    always_ff @(posedge clk)
        if (rst) begin
            clr_ptr    <= '0;
            write_addr <= '0;
            mask       <= '0;
            wr_done    <= 1'b0;
            mem_valid  <= 1'b0;
        end else begin
            clr_ptr   <= busy ? clr_ptr + 1'b1 : '0;
            wr_done   <= full;
            mem_valid <= rd;
            if (latch) begin
                write_addr <= bus.addr_data[ADDR_W-1:0];
                mask       <= '0;
            end else if (commit) mask <= full ? '0 : mask_n;
        end
    chunk_ram #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .CHUNK_W(CHUNK_W)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (busy ? clr_ptr : write_addr),
        .wdata (busy ? '0 : {NCHUNK{chunk}}),
        .re    (rd),
        .raddr (bus.addr_data[ADDR_W-1:0]),
        .rdata (bus.mem_result),
        .rperr (bus.parity_err)
    );
    assign bus.mem_valid = mem_valid;
    assign bus.wr_done   = wr_done;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_chunked_mem.sv
// tb_chunked_mem: directed checks of clear, chunked writes, reads and reset behaviour of chunked_mem.
module tb_chunked_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    chunked_mem_if bus ();
    chunked_mem_if #(.BUS_W(10), .WORD_W(18)) bus3 ();
    chunked_mem dut (.clk(clk), .rst(rst), .bus(bus.slave));
    chunked_mem #(.WORD_W(18)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
    always #5 clk = ~clk;

    task automatic cyc(input logic rw, input logic wc, input logic [9:0] ad);
        bus.read_write = rw;
        bus.write_commit = wc;
        bus.addr_data = ad;
        @(negedge clk);
    endtask

    task automatic cyc3(input logic rw, input logic wc, input logic [9:0] ad);
        bus3.read_write = rw;
        bus3.write_commit = wc;
        bus3.addr_data = ad;
        @(negedge clk);
    endtask

    task automatic test_reset;
        int n;
        bus.read_write = 1'b0; bus.write_commit = 1'b1; bus.addr_data = '0;
        bus3.read_write = 1'b1; bus3.write_commit = 1'b0; bus3.addr_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %0b want 1", bus.busy); end
        tests++; if (bus.mem_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", bus.mem_valid); end
        tests++; if (bus.wr_done !== 1'b0) begin fails++; $display("FAIL reset_wr_done: got %0b want 0", bus.wr_done); end
        tests++; if (bus.mem_result !== 12'h000) begin fails++; $display("FAIL reset_result: got %h want 000", bus.mem_result); end
        tests++; if (bus.parity_err !== 1'b0) begin fails++; $display("FAIL reset_parity: got %0b want 0", bus.parity_err); end
        rst = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 2000) begin n++; @(negedge clk); end
        tests++; if (n !== 1024) begin fails++; $display("FAIL clear_len: got %0d want 1024", n); end
        tests++; if (bus3.busy !== 1'b0) begin fails++; $display("FAIL clear_len_w18: got busy %0b want 0", bus3.busy); end
    endtask

    task automatic test_idle_commit;
        cyc(1'b0, 1'b1, 10'h07F);
        tests++; if (bus.wr_done !== 1'b0) begin fails++; $display("FAIL idle_commit_done: got %0b want 0", bus.wr_done); end
        tests++; if (bus.mem_valid !== 1'b0) begin fails++; $display("FAIL idle_commit_valid: got %0b want 0", bus.mem_valid); end
        cyc(1'b1, 1'b0, 10'h123);
        tests++; if (bus.mem_valid !== 1'b1) begin fails++; $display("FAIL read_valid: got %0b want 1", bus.mem_valid); end
        tests++; if (bus.mem_result !== 12'h000) begin fails++; $display("FAIL read_cleared: got %h want 000", bus.mem_result); end
        cyc(1'b0, 1'b1, 10'h07F);
        tests++; if (bus.mem_valid !== 1'b0) begin fails++; $display("FAIL valid_pulse: got %0b want 0", bus.mem_valid); end
        cyc(1'b1, 1'b0, 10'h000);
        tests++; if (bus.mem_result !== 12'h000) begin fails++; $display("FAIL idle_commit_word0: got %h want 000", bus.mem_result); end
        cyc(1'b1, 1'b0, 10'h07F);
        tests++; if (bus.mem_result !== 12'h000) begin fails++; $display("FAIL idle_commit_word7f: got %h want 000", bus.mem_result); end
    endtask

    task automatic test_write;
        cyc(1'b0, 1'b0, 10'h155);
        cyc(1'b0, 1'b1, 10'h06A);
        tests++; if (bus.wr_done !== 1'b0) begin fails++; $display("FAIL half_done: got %0b want 0", bus.wr_done); end
        cyc(1'b0, 1'b1, 10'h015);
        tests++; if (bus.wr_done !== 1'b1) begin fails++; $display("FAIL full_done: got %0b want 1", bus.wr_done); end
        cyc(1'b1, 1'b0, 10'h155);
        tests++; if (bus.wr_done !== 1'b0) begin fails++; $display("FAIL done_pulse: got %0b want 0", bus.wr_done); end
        tests++; if (bus.mem_result !== 12'hA95) begin fails++; $display("FAIL write_read: got %h want a95", bus.mem_result); end
    endtask

    task automatic test_back_to_back;
        cyc(1'b0, 1'b1, 10'h001);
        tests++; if (bus.wr_done !== 1'b0) begin fails++; $display("FAIL rearm_done: got %0b want 0", bus.wr_done); end
        cyc(1'b1, 1'b0, 10'h155);
        tests++; if (bus.mem_result !== 12'hA81) begin fails++; $display("FAIL partial_update: got %h want a81", bus.mem_result); end
        cyc(1'b0, 1'b1, 10'h07F);
        tests++; if (bus.wr_done !== 1'b1) begin fails++; $display("FAIL rearm_full: got %0b want 1", bus.wr_done); end
        cyc(1'b1, 1'b0, 10'h155);
        tests++; if (bus.mem_result !== 12'hFC1) begin fails++; $display("FAIL rearm_read: got %h want fc1", bus.mem_result); end
    endtask

    task automatic test_relatch;
        cyc(1'b0, 1'b0, 10'h3FF);
        cyc(1'b0, 1'b1, 10'h03F);
        cyc(1'b0, 1'b0, 10'h001);
        tests++; if (bus.wr_done !== 1'b0) begin fails++; $display("FAIL relatch_done: got %0b want 0", bus.wr_done); end
        cyc(1'b0, 1'b1, 10'h040);
        tests++; if (bus.wr_done !== 1'b0) begin fails++; $display("FAIL relatch_mask: got %0b want 0", bus.wr_done); end
        cyc(1'b1, 1'b0, 10'h3FF);
        tests++; if (bus.mem_result !== 12'h03F) begin fails++; $display("FAIL relatch_partial: got %h want 03f", bus.mem_result); end
        cyc(1'b0, 1'b0, 10'h002);
        cyc(1'b0, 1'b1, 10'h011);
        cyc(1'b0, 1'b1, 10'h022);
        tests++; if (bus.wr_done !== 1'b0) begin fails++; $display("FAIL rewrite_done: got %0b want 0", bus.wr_done); end
        cyc(1'b0, 1'b1, 10'h045);
        tests++; if (bus.wr_done !== 1'b1) begin fails++; $display("FAIL rewrite_full: got %0b want 1", bus.wr_done); end
        cyc(1'b1, 1'b0, 10'h002);
        tests++; if (bus.mem_result !== 12'h162) begin fails++; $display("FAIL rewrite_last_wins: got %h want 162", bus.mem_result); end
    endtask

    task automatic test_sel_range;
        cyc3(1'b0, 1'b0, 10'h020);
        cyc3(1'b0, 1'b1, 10'h0FF);
        tests++; if (bus3.wr_done !== 1'b0) begin fails++; $display("FAIL sel3_done: got %0b want 0", bus3.wr_done); end
        cyc3(1'b0, 1'b1, 10'h001);
        cyc3(1'b0, 1'b1, 10'h042);
        tests++; if (bus3.wr_done !== 1'b0) begin fails++; $display("FAIL w18_two_done: got %0b want 0", bus3.wr_done); end
        cyc3(1'b0, 1'b1, 10'h083);
        tests++; if (bus3.wr_done !== 1'b1) begin fails++; $display("FAIL w18_full: got %0b want 1", bus3.wr_done); end
        cyc3(1'b1, 1'b0, 10'h020);
        tests++; if (bus3.mem_result !== 18'h03081) begin fails++; $display("FAIL w18_read: got %h want 03081", bus3.mem_result); end
        cyc3(1'b0, 1'b1, 10'h0FF);
        cyc3(1'b0, 1'b1, 10'h005);
        cyc3(1'b0, 1'b1, 10'h046);
        tests++; if (bus3.wr_done !== 1'b0) begin fails++; $display("FAIL sel3_mask: got %0b want 0", bus3.wr_done); end
        cyc3(1'b1, 1'b0, 10'h020);
        tests++; if (bus3.mem_result !== 18'h03185) begin fails++; $display("FAIL sel3_ignored: got %h want 03185", bus3.mem_result); end
    endtask

    task automatic test_reset_during_clear;
        int n;
        int bad;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            case (i % 3)
                0: cyc(1'b0, 1'b0, 10'h155);
                1: cyc(1'b0, 1'b1, 10'h06A);
                default: cyc(1'b1, 1'b0, 10'h155);
            endcase
            if (bus.wr_done !== 1'b0 || bus.mem_valid !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL busy_ignore: got %0d bad cycles want 0", bad); end
        rst = 1'b1;
        @(negedge clk);
        tests++; if (bus.mem_result !== 12'h000) begin fails++; $display("FAIL rerst_result: got %h want 000", bus.mem_result); end
        rst = 1'b0;
        bus.read_write = 1'b1;
        n = 0;
        while (bus.busy === 1'b1 && n < 2000) begin n++; @(negedge clk); end
        tests++; if (n !== 1024) begin fails++; $display("FAIL reclear_len: got %0d want 1024", n); end
        cyc(1'b1, 1'b0, 10'h155);
        tests++; if (bus.mem_result !== 12'h000) begin fails++; $display("FAIL reclear_155: got %h want 000", bus.mem_result); end
        cyc(1'b1, 1'b0, 10'h002);
        tests++; if (bus.mem_result !== 12'h000) begin fails++; $display("FAIL reclear_002: got %h want 000", bus.mem_result); end
    endtask

    task automatic test_parity;
        cyc(1'b0, 1'b0, 10'h010);
        cyc(1'b0, 1'b1, 10'h06A);
        cyc(1'b0, 1'b1, 10'h015);
        tests++; if (bus.wr_done !== 1'b1) begin fails++; $display("FAIL par_wr_done: got %0b want 1", bus.wr_done); end
        cyc(1'b1, 1'b0, 10'h010);
        tests++; if (bus.mem_result !== 12'hA95) begin fails++; $display("FAIL par_read: got %h want a95", bus.mem_result); end
        tests++; if (bus.parity_err !== 1'b0) begin fails++; $display("FAIL par_clean: got %0b want 0", bus.parity_err); end
`ifdef MEM_PARITY_EN
        dut.u_ram.mem[16][3] = ~dut.u_ram.mem[16][3];
        cyc(1'b1, 1'b0, 10'h010);
        tests++; if (bus.mem_valid !== 1'b1) begin fails++; $display("FAIL par_valid: got %0b want 1", bus.mem_valid); end
        tests++; if (bus.parity_err !== 1'b1) begin fails++; $display("FAIL par_flip: got %0b want 1", bus.parity_err); end
        tests++; if (bus.mem_result !== 12'hA9D) begin fails++; $display("FAIL par_flip_data: got %h want a9d", bus.mem_result); end
        cyc(1'b1, 1'b0, 10'h155);
        tests++; if (bus.parity_err !== 1'b0) begin fails++; $display("FAIL par_other: got %0b want 0", bus.parity_err); end
`endif
    endtask

    initial begin
        test_reset();
        test_idle_commit();
        test_write();
        test_back_to_back();
        test_relatch();
        test_sel_range();
        test_reset_during_clear();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
